// File: rtl/lcd_pkg.sv
// Shared command codes, FSM state encoding and origin-default helper for the
// LCD window controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    CMD_REFLASH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5,
    CMD_MIRROR  = 3'd6,
    CMD_HOME    = 3'd7
  } lcd_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_UPDATE  = 2'd2,
    ST_DISPLAY = 2'd3
  } lcd_state_e;

  // Centre-ish origin (dim/2-1), pulled back so the window stays inside the image.
  function automatic int origin_default(input int dim, input int win);
    int d;
    d = dim / 2 - 1;
    return (d > dim - win) ? dim - win : d;
  endfunction

endpackage

// File: rtl/lcd_img_ram.sv
// Image buffer: one synchronous write port, one asynchronous read port.
// Addresses beyond DEPTH are ignored on write and read back as zero.
module lcd_img_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 36,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int RAW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) mem[waddr[RAW-1:0]] <= wdata;
  end

  assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr[RAW-1:0]] : '0;

endmodule

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads an IMG_W x IMG_H image, then streams a WIN x WIN
// window whose origin and horizontal mirror are steered by commands.
module lcd_win_ctrl
  import lcd_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int WIN   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy,
  output lcd_state_e    state_dbg
);
  localparam int N  = IMG_W * IMG_H;
  localparam int IW = $clog2(N) + 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] OX_DEF = XW'(origin_default(IMG_W, WIN));
  localparam logic [YW-1:0] OY_DEF = YW'(origin_default(IMG_H, WIN));
  localparam logic [XW-1:0] OX_MAX = XW'(IMG_W - WIN);
  localparam logic [YW-1:0] OY_MAX = YW'(IMG_H - WIN);

  // Handshake: a command is taken on a rising edge with cmd_valid=1 and busy=0;
  // busy rises on that edge and every cmd_valid seen while busy=1 is dropped.
  lcd_state_e    state_q, state_d;
  lcd_cmd_e      cmd_q;
  logic [IW-1:0] cnt_q, row_q, col_q;
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  logic          mirror_q;
  logic          accept;
  logic          load_done, disp_done;
  logic [IW-1:0] col_eff, rd_addr;
  logic [DW-1:0] rd_data;

  assign accept    = cmd_valid && !busy && (state_q == ST_IDLE);
  assign load_done = (cnt_q == IW'(N - 1));
  assign disp_done = (row_q == IW'(WIN));
  assign state_dbg = state_q;

  assign col_eff = mirror_q ? (IW'(WIN - 1) - col_q) : col_q;
  assign rd_addr = (IW'(oy_q) + row_q) * IW'(IMG_W) + IW'(ox_q) + col_eff;

  lcd_img_ram #(.DW(DW), .DEPTH(N), .AW(IW)) u_ram (
    .clk   (clk),
    .we    (state_q == ST_LOAD),
    .waddr (cnt_q),
    .wdata (datain),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (lcd_cmd_e'(cmd))
            CMD_REFLASH: state_d = ST_DISPLAY;
            CMD_LOAD:    state_d = ST_LOAD;
            default:     state_d = ST_UPDATE;
          endcase
        end
      end
      ST_LOAD:    if (load_done) state_d = ST_DISPLAY;
      ST_UPDATE:  state_d = ST_DISPLAY;
      ST_DISPLAY: if (disp_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy         <= 1'b0;
      output_valid <= 1'b0;
      dataout      <= '0;
      cmd_q        <= CMD_REFLASH;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ox_q         <= OX_DEF;
      oy_q         <= OY_DEF;
      mirror_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            cmd_q <= lcd_cmd_e'(cmd);
          end
        end
        ST_LOAD: begin
          if (load_done) begin
            cnt_q    <= '0;
            ox_q     <= OX_DEF;
            oy_q     <= OY_DEF;
            mirror_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + IW'(1);
          end
        end
        ST_UPDATE: begin
          case (cmd_q)
            CMD_RIGHT:  if (ox_q < OX_MAX) ox_q <= ox_q + XW'(1);
            CMD_LEFT:   if (ox_q != '0)    ox_q <= ox_q - XW'(1);
            CMD_UP:     if (oy_q != '0)    oy_q <= oy_q - YW'(1);
            CMD_DOWN:   if (oy_q < OY_MAX) oy_q <= oy_q + YW'(1);
            CMD_MIRROR: mirror_q <= ~mirror_q;
            CMD_HOME: begin
              ox_q     <= OX_DEF;
              oy_q     <= OY_DEF;
              mirror_q <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_DISPLAY: begin
          // One extra edge after the last pixel drops valid and busy together.
          if (disp_done) begin
            output_valid <= 1'b0;
            busy         <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
          end else begin
            output_valid <= 1'b1;
            dataout      <= rd_data;
            if (col_q == IW'(WIN - 1)) begin
              col_q <= '0;
              row_q <= row_q + IW'(1);
            end else begin
              col_q <= col_q + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl: 6x6/WIN=3 instance (A) and 8x8/WIN=4 instance (B).
module tb_lcd_win_ctrl;
  import lcd_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_datain = '0, a_dout;
  logic [2:0] a_cmd = '0;
  logic       a_valid = 1'b0, a_ov, a_busy;
  lcd_state_e a_st;

  logic [7:0] b_datain = '0, b_dout;
  logic [2:0] b_cmd = '0;
  logic       b_valid = 1'b0, b_ov, b_busy;
  lcd_state_e b_st;

  lcd_win_ctrl #(.DW(8), .IMG_W(6), .IMG_H(6), .WIN(3)) dut_a (
    .clk(clk), .reset(reset), .datain(a_datain), .cmd(a_cmd), .cmd_valid(a_valid),
    .dataout(a_dout), .output_valid(a_ov), .busy(a_busy), .state_dbg(a_st)
  );

  lcd_win_ctrl #(.DW(8), .IMG_W(8), .IMG_H(8), .WIN(4)) dut_b (
    .clk(clk), .reset(reset), .datain(b_datain), .cmd(b_cmd), .cmd_valid(b_valid),
    .dataout(b_dout), .output_valid(b_ov), .busy(b_busy), .state_dbg(b_st)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0_a = 0, e0_b = 0, lat_a = -1, lat_b = -1;
  logic prev_ov_a = 1'b0, prev_ov_b = 1'b0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] e_a, e_b;

  int load_win_a[9]  = '{14, 15, 16, 20, 21, 22, 26, 27, 28};
  int right_win_a[9] = '{15, 16, 17, 21, 22, 23, 27, 28, 29};
  int mirror_win_a[9] = '{2, 1, 0, 8, 7, 6, 14, 13, 12};
  int load_win_b[16] = '{27, 28, 29, 30, 35, 36, 37, 38, 43, 44, 45, 46, 51, 52, 53, 54};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: pop one expected pixel per valid output.
  always @(negedge clk) begin
    if (reset && a_ov) begin
      if (!prev_ov_a) lat_a = cyc - e0_a;
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_output: got %0d, required no output", a_dout);
      end else begin
        e_a = exp_a.pop_front();
        if (a_dout !== e_a) begin
          errors++;
          $display("FAIL a_pixel: got %0d, required %0d", a_dout, e_a);
        end
      end
    end
    prev_ov_a = a_ov;
  end

  always @(negedge clk) begin
    if (reset && b_ov) begin
      if (!prev_ov_b) lat_b = cyc - e0_b;
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_output: got %0d, required no output", b_dout);
      end else begin
        e_b = exp_b.pop_front();
        if (b_dout !== e_b) begin
          errors++;
          $display("FAIL b_pixel: got %0d, required %0d", b_dout, e_b);
        end
      end
    end
    prev_ov_b = b_ov;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (((which == 0) ? a_busy : b_busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_dut%0d: busy still 1 after %0d cycles, required 0", which, n);
    end
  endtask

  task automatic issue(input int which, input logic [2:0] c);
    wait_idle(which);
    @(negedge clk);
    if (which == 0) begin a_cmd = c; a_valid = 1'b1; end
    else            begin b_cmd = c; b_valid = 1'b1; end
    @(posedge clk);
    #1;
    if (which == 0) begin
      a_valid = 1'b0; e0_a = cyc; lat_a = -1;
      check("a_busy_after_accept", int'(a_busy), 1);
    end else begin
      b_valid = 1'b0; e0_b = cyc; lat_b = -1;
      check("b_busy_after_accept", int'(b_busy), 1);
    end
  endtask

  task automatic load_image(input int which, input int n);
    issue(which, CMD_LOAD);
    for (int i = 0; i < n; i++) begin
      if (which == 0) a_datain = 8'(i);
      else            b_datain = 8'(i);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_lat(input int which, input int want);
    wait_idle(which);
    if (which == 0) check("a_latency", lat_a, want);
    else            check("b_latency", lat_b, want);
  endtask

  // Reference window for image img[i]=i on instance A.
  task automatic push_win_a(input int ox, input int oy, input int m);
    int c;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        c = m ? (2 - k) : k;
        exp_a.push_back(8'((oy + r) * 6 + ox + c));
      end
    end
  endtask

  task automatic push_list_a(input int v[9]);
    for (int i = 0; i < 9; i++) exp_a.push_back(8'(v[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx, my;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_valid", int'(a_ov), 0);
    check("a_reset_busy", int'(a_busy), 0);
    check("a_reset_dout", int'(a_dout), 0);
    check("a_reset_state", int'(a_st), int'(ST_IDLE));
    check("b_reset_busy", int'(b_busy), 0);
    @(negedge clk);
    reset = 1'b1;

    push_list_a(load_win_a);
    load_image(0, 36);
    check_lat(0, 37);
    mx = 2; my = 2;

    // Right pulsed mid-display must be dropped.
    push_win_a(mx, my, 0);
    issue(0, CMD_REFLASH);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_cmd = CMD_RIGHT; a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    check("a_busy_during_display", int'(a_busy), 1);
    check("a_state_during_display", int'(a_st), int'(ST_DISPLAY));
    check_lat(0, 1);
    push_list_a(load_win_a);
    issue(0, CMD_REFLASH);
    check_lat(0, 1);

    for (int i = 0; i < 3; i++) begin
      mx = (mx < 3) ? mx + 1 : mx;
      push_win_a(mx, my, 0);
      issue(0, CMD_RIGHT);
      check_lat(0, 2);
    end
    push_list_a(right_win_a);
    issue(0, CMD_REFLASH);
    check_lat(0, 1);

    for (int i = 0; i < 3; i++) begin
      my = (my > 0) ? my - 1 : my;
      push_win_a(mx, my, 0);
      issue(0, CMD_UP);
      check_lat(0, 2);
    end
    for (int i = 0; i < 3; i++) begin
      mx = (mx > 0) ? mx - 1 : mx;
      push_win_a(mx, my, 0);
      issue(0, CMD_LEFT);
      check_lat(0, 2);
    end
    push_list_a(mirror_win_a);
    issue(0, CMD_MIRROR);
    check_lat(0, 2);
    push_list_a(load_win_a);
    issue(0, CMD_HOME);
    check_lat(0, 2);

    push_win_a(2, 3, 0);
    issue(0, CMD_DOWN);
    check_lat(0, 2);

    // Reset in the middle of a display aborts it.
    push_win_a(2, 3, 0);
    issue(0, CMD_REFLASH);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("a_abort_valid", int'(a_ov), 0);
    check("a_abort_busy", int'(a_busy), 0);
    check("a_abort_state", int'(a_st), int'(ST_IDLE));
    exp_a.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("a_after_abort_valid", int'(a_ov), 0);
    push_list_a(load_win_a);
    issue(0, CMD_REFLASH);
    check_lat(0, 1);

    for (int i = 0; i < 16; i++) exp_b.push_back(8'(load_win_b[i]));
    load_image(1, 64);
    check_lat(1, 65);

    repeat (3) @(posedge clk);
    check("a_queue_left", exp_a.size(), 0);
    check("b_queue_left", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
